// File: rtl/renas_ahb_arb_pkg.sv
// Shared AHB encodings and helpers for the renas per-slave arbiter.
// Holds the transfer/burst/response constants and the burst counter load rule.
package renas_ahb_arb_pkg;

  typedef logic [1:0] prio_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Beats still to come after the NONSEQ; undefined-length INCR counts as 0.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/renas_ahb_arbiter_pick.sv
// Combinational winner selection: highest level among requesters, ties broken
// by lowest index or by round-robin distance after the last granted index.
module renas_arb_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE    = 1,
  parameter int MW          = 2
) (
  input  logic [NUM_MASTERS-1:0]   req,
  input  logic [3*NUM_MASTERS-1:0] level,
  input  logic [MW-1:0]            rr_ptr,
  output logic [NUM_MASTERS-1:0]   win_onehot,
  output logic [MW-1:0]            win_idx,
  output logic                     win_valid
);
  import renas_ahb_arb_pkg::*;

  logic [2:0]             max_lvl;
  logic [NUM_MASTERS-1:0] cand;

  always_comb begin
    max_lvl = 3'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (req[i] && (level[3*i +: 3] > max_lvl)) max_lvl = level[3*i +: 3];
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
    assign cand[gi] = req[gi] && (level[3*gi +: 3] == max_lvl);
  end

  assign win_valid = |cand;

  // Round-robin distance: the index right after rr_ptr is 0, rr_ptr itself is last.
  always_comb begin
    int best_d;
    int d;
    best_d  = NUM_MASTERS;
    d       = 0;
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_MODE == 0) d = i;
      else               d = (i - int'(rr_ptr) - 1 + 2 * NUM_MASTERS) % NUM_MASTERS;
      if (cand[i] && (d < best_d)) begin
        best_d  = d;
        win_idx = MW'(i);
      end
    end
    win_onehot = win_valid ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/renas_ahb_arbiter.sv
// Per-slave-port AHB arbiter: weighted priority with round-robin ties and
// starvation aging, holding the grant through fixed bursts and locked sequences.
module renas_ahb_arbiter
  import renas_ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int ARB_MODE       = 1,
  parameter  int STARVE_LIMIT   = 8,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [2*NUM_MASTERS-1:0] hprior,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  input  logic [1:0]               hresp,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [MW-1:0]            hmaster,
  output logic [MW-1:0]            hmaster_data,
  output logic                     hmastlock
);

  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
  logic [MW-1:0]            grant_idx_reg, grant_idx_next;
  logic [MW-1:0]            hmaster_reg, hmaster_data_reg;
  logic                     hmastlock_reg;
  logic [3:0]               cnt_reg, cnt_next, cnt_base;
  logic [AW-1:0]            age_reg [NUM_MASTERS];
  logic [AW-1:0]            age_next [NUM_MASTERS];
  logic [MW-1:0]            rr_reg, rr_next;
  logic [3*NUM_MASTERS-1:0] level;
  logic [NUM_MASTERS-1:0]   win_onehot;
  logic [MW-1:0]            win_idx;
  logic                     win_valid;
  logic                     rearb;

  // A starving requester jumps above every programmable priority.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_level
    prio_t prio_w;
    assign prio_w = hprior[2*gi +: 2];
    assign level[3*gi +: 3] = (age_reg[gi] >= AW'(STARVE_LIMIT)) ? 3'd4 : {1'b0, prio_w};
  end

  renas_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE),
    .MW          (MW)
  ) u_pick (
    .req        (hbusreq),
    .level      (level),
    .rr_ptr     (rr_reg),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign rearb = hready
               & ~(hlock[grant_idx_reg] & hbusreq[grant_idx_reg])
               & ((cnt_reg == 4'd0) | ((cnt_reg == 4'd1) & (htrans == HTRANS_SEQ)));

  // An ERROR response cancels the burst before this beat's transfer is applied.
  always_comb begin
    cnt_base = (hresp == HRESP_ERROR) ? 4'd0 : cnt_reg;
    case (htrans)
      HTRANS_NONSEQ: cnt_next = burst_beats(hburst);
      HTRANS_SEQ:    cnt_next = (cnt_base != 4'd0) ? cnt_base - 4'd1 : 4'd0;
      HTRANS_IDLE:   cnt_next = 4'd0;
      default:       cnt_next = cnt_base;
    endcase
  end

  always_comb begin
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    rr_next        = rr_reg;
    for (int i = 0; i < NUM_MASTERS; i++) age_next[i] = age_reg[i];
    if (rearb) begin
      grant_next     = win_valid ? win_onehot : DEF_ONEHOT;
      grant_idx_next = win_valid ? win_idx : DEF_IDX;
      if (win_valid) rr_next = win_idx;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (hbusreq[i] && !win_onehot[i])
          age_next[i] = (age_reg[i] >= AW'(STARVE_LIMIT)) ? AW'(STARVE_LIMIT) : age_reg[i] + 1'b1;
        else
          age_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg        <= DEF_ONEHOT;
      grant_idx_reg    <= DEF_IDX;
      hmaster_reg      <= DEF_IDX;
      hmaster_data_reg <= DEF_IDX;
      hmastlock_reg    <= 1'b0;
      cnt_reg          <= 4'd0;
      rr_reg           <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) age_reg[i] <= '0;
    end else if (hready) begin
      grant_reg        <= grant_next;
      grant_idx_reg    <= grant_idx_next;
      hmaster_reg      <= grant_idx_reg;
      hmaster_data_reg <= hmaster_reg;
      hmastlock_reg    <= hlock[grant_idx_reg];
      cnt_reg          <= cnt_next;
      rr_reg           <= rr_next;
      for (int i = 0; i < NUM_MASTERS; i++) age_reg[i] <= age_next[i];
    end
  end

  assign hgrant       = grant_reg;
  assign hmaster      = hmaster_reg;
  assign hmaster_data = hmaster_data_reg;
  assign hmastlock    = hmastlock_reg;

endmodule

// File: doc/renas_ahb_arbiter.md
Name: renas_ahb_arbiter

Overview:
Parametrised N-master arbiter for the renas multi-master AHB matrix. It replaces the tied-off per-master priority inputs with live weighted arbitration. It issues the registered grant, the address-phase master index and the data-phase master index. It respects fixed-length bursts and locked transfers, and adds round-robin tie-breaking and starvation aging, which the current matrix lacks. One instance sits in front of each slave port; the master-to-slave mux consumes hmaster/hmaster_data.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
DEFAULT_MASTER, 0, index granted when nobody requests and after reset
ARB_MODE, 1, tie-break among equal priority: 0 = lowest index, 1 = round-robin after last granted index
STARVE_LIMIT, 8, lost arbitration opportunities before a requester is promoted to urgent
MW (localparam), $clog2(NUM_MASTERS), width of master index

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, synchronous, active-high
hbusreq  in  NUM_MASTERS  bus request per master
hlock  in  NUM_MASTERS  lock request per master
hprior  in  2*NUM_MASTERS  2-bit priority per master, 3 = highest
htrans  in  2  slave-side (muxed) HTRANS
hburst  in  3  slave-side (muxed) HBURST
hready  in  1  slave-side HREADY
hresp  in  2  slave-side HRESP (2'b01 = ERROR)
hgrant  out  NUM_MASTERS  one-hot grant
hmaster  out  MW  address-phase owner index
hmaster_data  out  MW  data-phase owner index
hmastlock  out  1  current address phase is locked

Behaviour:
- Reset (rst=1 at posedge, regardless of hready):
  - hgrant = one-hot DEFAULT_MASTER; hmaster = hmaster_data = DEFAULT_MASTER; hmastlock = 0.
  - Beat counter, age counters and RR pointer all cleared.
- Freeze: hready=0 holds every register: grant, indices, counters, ages.
- Pipeline on each posedge with hready=1:
  - hmaster <= index(hgrant); hmastlock <= hlock[index(hgrant)].
  - hmaster_data <= hmaster.
  - Grant-to-address latency 1 cycle; address-to-data latency 1 cycle.
- Beat counter (remaining beats of hmaster's burst), updated with hready=1:
  - NONSEQ: load 3 / 7 / 15 for INCR4|WRAP4 / INCR8|WRAP8 / INCR16|WRAP16; load 0 for SINGLE or INCR.
  - SEQ: decrement when nonzero.
  - IDLE, or NONSEQ while count > 0 (early termination): clear, then apply the NONSEQ load rule.
  - hresp = ERROR: clear.
- Re-arbitration opportunity (rearb) = hready & !(hlock[grant holder] & hbusreq[grant holder]) & (cnt==0 | (cnt==1 & htrans==SEQ)).
  - Undefined-length INCR (cnt==0) may be preempted at any accepted beat.
- Winner selection at rearb:
  - Effective level = 4 if age[i] >= STARVE_LIMIT, else hprior[i]. Highest level among hbusreq=1 wins.
  - Ties: ARB_MODE rule; the RR pointer updates to the winner.
  - No requests: DEFAULT_MASTER.
  - The current holder participates normally.
- Grant hold: no rearb leaves hgrant unchanged even if a higher-priority request appears.
- Aging: at each rearb, every requesting non-winner increments age (saturating at STARVE_LIMIT); the winner and non-requesters clear to 0.
- Simultaneous events: reset dominates everything; lock dominates burst end and aging; ERROR plus a new NONSEQ in the same cycle means clear first, then load.

Decomposition:
- Package renas_ahb_arb_pkg holds:
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ.
  - HBURST encodings and HRESP_ERROR.
  - Function burst_beats(hburst) returning the counter load.
  - Typedef prio_t (logic [1:0]).
- Sub-module renas_arb_pick (combinational): given request vector, levels and RR pointer, returns the one-hot winner. The level/round-robin logic can then be unit-tested alone.

Test Plan:
1. Reset: rst=1 for 2 cycles with hbusreq=4'b1111 -> hgrant=4'b0001, hmaster=0, hmaster_data=0, hmastlock=0; no change until the first posedge after rst=0.
2. Priority: hbusreq=4'b1010, hprior m1=1, m3=2, hready=1 -> hgrant=4'b1000 next edge, hmaster=3 the edge after, hmaster_data=3 one edge later.
3. Burst hold: m1 granted, issues INCR4 (NONSEQ + 3 SEQ); m2 (prio 3) requests at beat 2 -> hgrant stays 4'b0010 until the edge accepting beat 4's address, then 4'b0100.
4. Wait states: hready=0 for 3 cycles mid-burst with competing requests -> all outputs constant; burst resumes with the correct count.
5. Round-robin and aging:
   - All four request at prio 1 with SINGLE transfers -> grant sequence m0, m1, m2, m3, m0.
   - Then m0 at prio 0 and m1 at prio 3 continuously with STARVE_LIMIT=8 -> m0 granted at the 9th opportunity, its age reset, then m1 again.
6. Lock and error:
   - m2 with hlock=1 keeps the grant despite a prio-3 requester; hmastlock=1 during its addresses.
   - ERROR response mid-INCR8 clears the counter -> regrant at the next accepted beat.
